// File: rtl/aes_csr_engine.sv
// AES CSR sequencer: fetches a 4-word key from key memory, launches the
// external AES core, captures its result and pulses aes_done. Every wait
// (per key word, and for the core) is bounded by TIMEOUT cycles; expiry
// aborts the operation with a sticky error and zeroed result words.
module aes_csr_engine #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  aes_d0,
    input  logic [31:0]  aes_d1,
    input  logic [31:0]  aes_d2,
    input  logic [31:0]  aes_d3,
    input  logic [31:0]  aes_key_addr,
    output logic         key_req,
    output logic [31:0]  key_addr,
    input  logic [31:0]  key_rdata,
    input  logic         key_valid,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic [31:0]  aes_res0,
    output logic [31:0]  aes_res1,
    output logic [31:0]  aes_res2,
    output logic [31:0]  aes_res3,
    output logic         aes_done,
    output logic         busy,
    output logic         error
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        next_state;
    logic [31:0]   base;
    logic [1:0]    index;
    logic [CW-1:0] cnt;
    logic          expired;

    logic          accept;
    logic          word_store;
    logic          res_capture;
    logic          abort;
    logic          cnt_inc;

    assign expired  = (cnt == CW'(TIMEOUT));
    assign key_addr = base + {28'd0, index, 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and control strobes; a valid/done seen on the
    // expiry cycle takes priority over the timeout abort
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        word_store  = 1'b0;
        res_capture = 1'b0;
        abort       = 1'b0;
        cnt_inc     = 1'b0;
        key_req     = 1'b0;
        core_start  = 1'b0;
        aes_done    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                key_req = 1'b1;
                if (key_valid) begin
                    word_store = 1'b1;
                    if (index == 2'd3) begin
                        next_state = LAUNCH;
                    end
                end else if (expired) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    res_capture = 1'b1;
                    next_state  = DONE;
                end else if (expired) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                aes_done   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, key word assembly, wait counter, results
    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            index    <= '0;
            cnt      <= '0;
            core_key <= '0;
            core_din <= '0;
            aes_res0 <= '0;
            aes_res1 <= '0;
            aes_res2 <= '0;
            aes_res3 <= '0;
            error    <= 1'b0;
        end else begin
            if (accept) begin
                core_din <= {aes_d0, aes_d1, aes_d2, aes_d3};
                base     <= aes_key_addr & 32'hFFFF_FFFC;
                index    <= '0;
                error    <= 1'b0;
            end

            if (word_store) begin
                case (index)
                    2'd0:    core_key[127:96] <= key_rdata;
                    2'd1:    core_key[95:64]  <= key_rdata;
                    2'd2:    core_key[63:32]  <= key_rdata;
                    default: core_key[31:0]   <= key_rdata;
                endcase
                index <= index + 2'd1;
            end

            // Counter restarts for every key word and on entry to WAIT
            if (accept || word_store || state == LAUNCH) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end

            if (res_capture) begin
                aes_res0 <= core_dout[127:96];
                aes_res1 <= core_dout[95:64];
                aes_res2 <= core_dout[63:32];
                aes_res3 <= core_dout[31:0];
            end else if (abort) begin
                aes_res0 <= '0;
                aes_res1 <= '0;
                aes_res2 <= '0;
                aes_res3 <= '0;
                error    <= 1'b1;
            end
        end
    end

endmodule
